util_stream_checker: RTL

AXI-Stream sink that regenerates the deterministic byte sequence produced by `util_stream_master` (start value, increment, fixed mode, transfer length, packet count), compares every received beat against it, and reports beat/packet/error counts. Sits at the receive end of a loopback or link test (e.g. after a `uart_receiver`) so software can qualify a path with one start pulse and a counter read.

---
 rtl/util_stream_checker.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/util_stream_checker.sv
// rtl/util_stream_checker.sv - AXI-Stream sink that checks a deterministic byte sequence and counts beats/packets/errors
// Optional feature macro: UTIL_STREAM_CHECKER_FIRST_ERR_EN (first-mismatch capture ports)
module util_stream_checker #(
  parameter int TBYTE_NUM = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   check_start,
  input  logic                   check_abort,
  input  logic [7:0]             start_from,
  input  logic [7:0]             inc,
  input  logic                   fix,
  input  logic [31:0]            trans_len,
  input  logic [31:0]            pkt_num,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [8*TBYTE_NUM-1:0] s_axis_tdata,
  output logic                   check_busy,
  output logic                   check_done,
  output logic [31:0]            beat_cnt,
  output logic [31:0]            pkt_cnt,
  output logic [31:0]            err_cnt,
  output logic                   err_flag
`ifdef UTIL_STREAM_CHECKER_FIRST_ERR_EN
  ,
  output logic [31:0]            first_err_beat,
  output logic [8*TBYTE_NUM-1:0] first_err_exp,
  output logic [8*TBYTE_NUM-1:0] first_err_got
`endif
);

  localparam int DW = 8 * TBYTE_NUM;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    state;

  // Run configuration, frozen at the accepted start so live inputs cannot disturb a run
  logic [7:0]    cfg_start;
  logic [7:0]    cfg_inc;
  logic          cfg_fix;
  logic [31:0]   cfg_len;
  logic [31:0]   cfg_pkts;

  // Expected value of lane 0 for the current beat, and position within the packet
  logic [7:0]    base;
  logic [31:0]   beat_in_pkt;

  logic [DW-1:0] exp_data;
  logic [7:0]    base_step;
  logic          accept;
  logic          beat_bad;
  logic          last_beat;
  logic [31:0]   pkt_next;

  assign s_axis_tready = (state == ST_RUN);
  assign check_busy    = (state == ST_RUN) || (state == ST_DONE);
  assign check_done    = (state == ST_DONE);

  assign base_step = 8'(TBYTE_NUM) * cfg_inc;
  assign accept    = (state == ST_RUN) && s_axis_tvalid;
  assign beat_bad  = (s_axis_tdata != exp_data);
  assign last_beat = (beat_in_pkt == cfg_len - 32'd1);
  assign pkt_next  = pkt_cnt + 32'd1;

  // Expected beat: each lane steps by inc from base, or all lanes equal start in fixed mode
  always_comb begin
    exp_data = '0;
    for (int i = 0; i < TBYTE_NUM; i++) begin
      exp_data[i*8 +: 8] = cfg_fix ? cfg_start : (base + 8'(i) * cfg_inc);
    end
  end

  // Control state, configuration latch, sequence position and run counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cfg_start   <= '0;
      cfg_inc     <= '0;
      cfg_fix     <= 1'b0;
      cfg_len     <= '0;
      cfg_pkts    <= '0;
      base        <= '0;
      beat_in_pkt <= '0;
      beat_cnt    <= '0;
      pkt_cnt     <= '0;
      err_cnt     <= '0;
      err_flag    <= 1'b0;
    end else if (check_abort) begin
      // Abort leaves the counters readable for software
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (check_start) begin
            cfg_start   <= start_from;
            cfg_inc     <= inc;
            cfg_fix     <= fix;
            cfg_len     <= trans_len;
            cfg_pkts    <= pkt_num;
            base        <= start_from;
            beat_in_pkt <= '0;
            beat_cnt    <= '0;
            pkt_cnt     <= '0;
            err_cnt     <= '0;
            err_flag    <= 1'b0;
            state       <= ((trans_len == 32'd0) || (pkt_num == 32'd0)) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (accept) begin
            beat_cnt <= beat_cnt + 32'd1;
            if (beat_bad) begin
              err_flag <= 1'b1;
              if (err_cnt != 32'hFFFF_FFFF) begin
                err_cnt <= err_cnt + 32'd1;
              end
            end
            if (last_beat) begin
              // Every packet restarts the sequence from the start value
              beat_in_pkt <= '0;
              base        <= cfg_start;
              pkt_cnt     <= pkt_next;
              if (pkt_next == cfg_pkts) begin
                state <= ST_DONE;
              end
            end else begin
              beat_in_pkt <= beat_in_pkt + 32'd1;
              if (!cfg_fix) begin
                base <= base + base_step;
              end
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef UTIL_STREAM_CHECKER_FIRST_ERR_EN
  // First mismatch of the run: beat index, expected and received data, captured once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_err_beat <= '0;
      first_err_exp  <= '0;
      first_err_got  <= '0;
    end else if (!check_abort) begin
      if ((state == ST_IDLE) && check_start) begin
        first_err_beat <= '0;
        first_err_exp  <= '0;
        first_err_got  <= '0;
      end else if (accept && beat_bad && !err_flag) begin
        first_err_beat <= beat_cnt;
        first_err_exp  <= exp_data;
        first_err_got  <= s_axis_tdata;
      end
    end
  end
`endif

endmodule
